// File: rtl/cp0_access_ctrl.sv
// Single sequencer for every CP0 register-file access: pipeline MFC0/MTC0, exception entry, ERET.
// Pipeline ops ack 1 cycle after accept, exception entry 7, ERET 3; new requests wait while busy.
module cp0_access_ctrl #(
  parameter int EXL_BIT = 1,
  parameter int BD_BIT  = 31
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cp0_req,
  input  logic        cp0_we,
  input  logic [4:0]  cp0_rd,
  input  logic [3:0]  cp0_sel,
  input  logic [31:0] cp0_wdata,
  output logic        cp0_ack,
  output logic [31:0] cp0_rdata,
  input  logic        exc_req,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_epc,
  input  logic        exc_bd,
  input  logic [31:0] exc_badv,
  input  logic        exc_badv_vld,
  output logic        exc_ack,
  input  logic        eret_req,
  output logic        eret_ack,
  output logic [31:0] eret_pc,
  output logic [4:0]  map_rd,
  output logic [3:0]  map_sel,
  input  logic [5:0]  map_num,
  input  logic        map_vld,
  output logic [5:0]  rf_raddr,
  input  logic [31:0] rf_rdata,
  output logic        rf_we,
  output logic [5:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        busy
);

  localparam logic [5:0] IDX_BADV   = 6'd8;
  localparam logic [5:0] IDX_STATUS = 6'd15;
  localparam logic [5:0] IDX_CAUSE  = 6'd16;
  localparam logic [5:0] IDX_EPC    = 6'd17;
  localparam logic [31:0] EXL_MASK  = 32'd1 << EXL_BIT;

  typedef enum logic [3:0] {
    IDLE, PIPE,
    EXC_RS, EXC_RC, EXC_EPC, EXC_BV, EXC_WC, EXC_WS, EXC_ACK,
    ER_RD, ER_WS, ER_ACK
  } state_t;

  state_t      state, state_nx;
  logic [31:0] status_q, cause_q;
  logic [31:0] cause_new;
  logic        pipe_go;

  assign map_rd  = cp0_rd;
  assign map_sel = cp0_sel;
  assign busy    = (state != IDLE);
  assign pipe_go = (state == IDLE) && cp0_req && !exc_req && !eret_req;

  // BD is only refreshed on a first-level exception; nested entries keep the original slot flag
  always_comb begin
    cause_new      = cause_q;
    cause_new[6:2] = exc_code;
    if (!status_q[EXL_BIT])
      cause_new[BD_BIT] = exc_bd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      status_q  <= '0;
      cause_q   <= '0;
      cp0_rdata <= '0;
      eret_pc   <= '0;
    end else begin
      state <= state_nx;
      if (pipe_go)
        cp0_rdata <= (!cp0_we && map_vld) ? rf_rdata : 32'd0;
      if (state == EXC_RS) status_q <= rf_rdata;
      if (state == EXC_RC) cause_q  <= rf_rdata;
      if (state == ER_RD)  eret_pc  <= rf_rdata;
    end
  end

  always_comb begin
    state_nx = state;
    cp0_ack  = 1'b0;
    exc_ack  = 1'b0;
    eret_ack = 1'b0;
    rf_raddr = '0;
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    case (state)
      IDLE: begin
        if (exc_req)
          state_nx = EXC_RS;
        else if (eret_req)
          state_nx = ER_RD;
        else if (cp0_req) begin
          state_nx = PIPE;
          if (cp0_we) begin
            rf_we    = map_vld;
            rf_waddr = map_num;
            rf_wdata = cp0_wdata;
          end else begin
            rf_raddr = map_num;
          end
        end
      end
      PIPE: begin
        cp0_ack  = 1'b1;
        state_nx = IDLE;
      end
      EXC_RS: begin
        rf_raddr = IDX_STATUS;
        state_nx = EXC_RC;
      end
      EXC_RC: begin
        rf_raddr = IDX_CAUSE;
        state_nx = EXC_EPC;
      end
      EXC_EPC: begin
        rf_we    = !status_q[EXL_BIT];
        rf_waddr = IDX_EPC;
        rf_wdata = exc_epc;
        state_nx = EXC_BV;
      end
      EXC_BV: begin
        rf_we    = exc_badv_vld;
        rf_waddr = IDX_BADV;
        rf_wdata = exc_badv;
        state_nx = EXC_WC;
      end
      EXC_WC: begin
        rf_we    = 1'b1;
        rf_waddr = IDX_CAUSE;
        rf_wdata = cause_new;
        state_nx = EXC_WS;
      end
      EXC_WS: begin
        rf_we    = 1'b1;
        rf_waddr = IDX_STATUS;
        rf_wdata = status_q | EXL_MASK;
        state_nx = EXC_ACK;
      end
      EXC_ACK: begin
        exc_ack  = 1'b1;
        state_nx = IDLE;
      end
      ER_RD: begin
        rf_raddr = IDX_EPC;
        state_nx = ER_WS;
      end
      // Single read port: Status is read here and written back the same cycle; the write lands at the edge
      ER_WS: begin
        rf_raddr = IDX_STATUS;
        rf_we    = 1'b1;
        rf_waddr = IDX_STATUS;
        rf_wdata = rf_rdata & ~EXL_MASK;
        state_nx = ER_ACK;
      end
      ER_ACK: begin
        eret_ack = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cp0_access_ctrl.sv
// Bench for cp0_access_ctrl: register-file/mapper environment, transaction-level model, directed and random requests.
module tb_cp0_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cp0_req, cp0_we, cp0_ack;
  logic [4:0]  cp0_rd;
  logic [3:0]  cp0_sel;
  logic [31:0] cp0_wdata, cp0_rdata;
  logic        exc_req, exc_bd, exc_badv_vld, exc_ack;
  logic [4:0]  exc_code;
  logic [31:0] exc_epc, exc_badv;
  logic        eret_req, eret_ack;
  logic [31:0] eret_pc;
  logic [4:0]  map_rd;
  logic [3:0]  map_sel;
  logic [5:0]  map_num;
  logic        map_vld;
  logic [5:0]  rf_raddr, rf_waddr;
  logic [31:0] rf_rdata, rf_wdata;
  logic        rf_we, busy;

  always #5 clk = ~clk;

  cp0_access_ctrl #(.EXL_BIT(1), .BD_BIT(31)) dut (
    .clk(clk), .rst_n(rst_n),
    .cp0_req(cp0_req), .cp0_we(cp0_we), .cp0_rd(cp0_rd), .cp0_sel(cp0_sel),
    .cp0_wdata(cp0_wdata), .cp0_ack(cp0_ack), .cp0_rdata(cp0_rdata),
    .exc_req(exc_req), .exc_code(exc_code), .exc_epc(exc_epc), .exc_bd(exc_bd),
    .exc_badv(exc_badv), .exc_badv_vld(exc_badv_vld), .exc_ack(exc_ack),
    .eret_req(eret_req), .eret_ack(eret_ack), .eret_pc(eret_pc),
    .map_rd(map_rd), .map_sel(map_sel), .map_num(map_num), .map_vld(map_vld),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .busy(busy)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    tests++;
    fails++;
    $display("FAIL %s: no ack within cycle budget (t=%0t)", nm, $time);
  endtask

  // ---------------- environment: rd/sel mapper and 39-entry register file
  function automatic logic [6:0] map_fn(input logic [4:0] rd, input logic [3:0] sel);
    logic [6:0] r;
    r = 7'd0;
    if (sel == 4'd0) begin
      if (rd == 5'd12)      r = {1'b1, 6'd15};
      else if (rd == 5'd13) r = {1'b1, 6'd16};
      else if (rd == 5'd14) r = {1'b1, 6'd17};
      else if (rd < 5'd12)  r = {1'b1, 1'b0, rd};
      else                  r = {1'b1, 6'({1'b0, rd} + 6'd3)};
    end else if (sel == 4'd1 && rd < 5'd4) begin
      r = {1'b1, 6'(6'd35 + {1'b0, rd})};
    end
    return r;
  endfunction

  function automatic logic [31:0] init_val(input int i);
    return (i == 15 || i == 16) ? 32'd0 : (32'hA500_0000 | 32'(i));
  endfunction

  logic [31:0] rf [0:63];
  logic        env_load = 1'b1;

  assign {map_vld, map_num} = map_fn(map_rd, map_sel);
  assign rf_rdata = rf[rf_raddr];

  always @(posedge clk) begin
    if (env_load) begin
      for (int i = 0; i < 64; i++) rf[i] <= init_val(i);
    end else if (rf_we) begin
      rf[rf_waddr] <= rf_wdata;
    end
  end

  // ---------------- transaction-level model
  logic [31:0] mrf [0:63];
  logic [31:0] pre_badv, pre_status, pre_cause, pre_epc;
  bit          m_act = 0;
  int          m_kind, m_start, m_len, cyc = 0;
  logic [31:0] m_rdata, m_pc;
  bit          m_chk_rdata;
  bit          chk_on = 0;

  initial begin : model
    logic [6:0]  mp;
    logic [31:0] c;
    logic        exl;
    int          off;
    forever begin
      @(posedge clk);
      if (env_load) begin
        for (int i = 0; i < 64; i++) mrf[i] = init_val(i);
      end
      if (!rst_n) begin
        // abort: only the writes whose cycle already completed survive
        if (m_act && m_kind == 1) begin
          off = cyc - m_start;
          if (off <= 2) mrf[17] = pre_epc;
          if (off <= 3) mrf[8]  = pre_badv;
          if (off <= 4) mrf[16] = pre_cause;
          if (off <= 5) mrf[15] = pre_status;
        end
        m_act = 0;
      end else begin
        cyc++;
        if (!m_act) begin
          if (exc_req) begin
            pre_badv = mrf[8]; pre_status = mrf[15]; pre_cause = mrf[16]; pre_epc = mrf[17];
            exl = mrf[15][1];
            if (!exl) mrf[17] = exc_epc;
            if (exc_badv_vld) mrf[8] = exc_badv;
            c = mrf[16];
            c[6:2] = exc_code;
            if (!exl) c[31] = exc_bd;
            mrf[16] = c;
            mrf[15] = mrf[15] | 32'h2;
            m_kind = 1; m_len = 7; m_act = 1; m_start = cyc;
          end else if (eret_req) begin
            m_pc = mrf[17];
            mrf[15] = mrf[15] & ~32'h2;
            m_kind = 2; m_len = 3; m_act = 1; m_start = cyc;
          end else if (cp0_req) begin
            mp = map_fn(cp0_rd, cp0_sel);
            if (cp0_we) begin
              if (mp[6]) mrf[mp[5:0]] = cp0_wdata;
              m_chk_rdata = 0;
            end else begin
              m_rdata = mp[6] ? mrf[mp[5:0]] : 32'd0;
              m_chk_rdata = 1;
            end
            m_kind = 0; m_len = 1; m_act = 1; m_start = cyc;
          end
        end else if (cyc == m_start + m_len) begin
          m_act = 0;
        end
      end
    end
  end

  // ---------------- per-cycle compare against the model
  initial begin : compare
    bit e_cp0, e_exc, e_eret, e_busy;
    int bad;
    forever begin
      @(negedge clk);
      if (rst_n && chk_on) begin
        e_busy = m_act && (cyc <= m_start + m_len - 1);
        e_cp0  = m_act && m_kind == 0 && cyc == m_start + m_len - 1;
        e_exc  = m_act && m_kind == 1 && cyc == m_start + m_len - 1;
        e_eret = m_act && m_kind == 2 && cyc == m_start + m_len - 1;
        chk("busy", busy, e_busy);
        chk("cp0_ack", cp0_ack, e_cp0);
        chk("exc_ack", exc_ack, e_exc);
        chk("eret_ack", eret_ack, e_eret);
        if (e_cp0 && m_chk_rdata) chk("cp0_rdata", cp0_rdata, m_rdata);
        if (e_eret) chk("eret_pc", eret_pc, m_pc);
        if (e_cp0 || e_exc || e_eret) begin
          bad = 0;
          for (int i = 0; i < 39; i++) if (rf[i] !== mrf[i]) bad++;
          chk("rf_state_mismatches", bad, 0);
        end
      end
    end
  end

  // ---------------- requesters (enter and leave 1 time unit after a rising edge)
  localparam int BUDGET = 300;

  task automatic do_cp0(input logic we, input logic [4:0] rd, input logic [3:0] sel,
                        input logic [31:0] wd, output logic [31:0] rdat, output int lat);
    cp0_we = we; cp0_rd = rd; cp0_sel = sel; cp0_wdata = wd; cp0_req = 1'b1;
    lat = 0;
    @(negedge clk);
    while (!cp0_ack && lat < BUDGET) begin lat++; @(negedge clk); end
    rdat = cp0_rdata;
    if (!cp0_ack) timeout("cp0_ack_wait");
    @(posedge clk); #1 cp0_req = 1'b0;
  endtask

  task automatic do_exc(input logic [4:0] code, input logic [31:0] epc, input logic bd,
                        input logic [31:0] badv, input logic bvld, output int lat);
    exc_code = code; exc_epc = epc; exc_bd = bd; exc_badv = badv; exc_badv_vld = bvld;
    exc_req = 1'b1;
    lat = 0;
    @(negedge clk);
    while (!exc_ack && lat < BUDGET) begin lat++; @(negedge clk); end
    if (!exc_ack) timeout("exc_ack_wait");
    @(posedge clk); #1 exc_req = 1'b0;
  endtask

  task automatic do_eret(output logic [31:0] pc, output int lat);
    eret_req = 1'b1;
    lat = 0;
    @(negedge clk);
    while (!eret_ack && lat < BUDGET) begin lat++; @(negedge clk); end
    pc = eret_pc;
    if (!eret_ack) timeout("eret_ack_wait");
    @(posedge clk); #1 eret_req = 1'b0;
  endtask

  task automatic idle_rand();
    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
  endtask

  // ---------------- directed then random stimulus
  initial begin : main
    logic [31:0] rd_v, pc_v;
    int lat_a, lat_b, lat_c;
    rst_n = 1'b0;
    cp0_req = 0; cp0_we = 0; cp0_rd = 0; cp0_sel = 0; cp0_wdata = 0;
    exc_req = 0; exc_code = 0; exc_epc = 0; exc_bd = 0; exc_badv = 0; exc_badv_vld = 0;
    eret_req = 0;
    repeat (3) @(posedge clk);
    #1 env_load = 1'b0;
    chk("rst_cp0_ack", cp0_ack, 0);
    chk("rst_exc_ack", exc_ack, 0);
    chk("rst_eret_ack", eret_ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_cp0_rdata", cp0_rdata, 0);
    chk("rst_eret_pc", eret_pc, 0);
    chk("rst_rf_addrs", {20'd0, rf_raddr, rf_waddr}, 0);
    chk("rst_rf_wdata", rf_wdata, 0);
    @(posedge clk); #1 rst_n = 1'b1; chk_on = 1;
    @(posedge clk); #1;

    // MTC0 Status: write strobe in the accept cycle, ack one cycle later
    cp0_we = 1; cp0_rd = 5'd12; cp0_sel = 0; cp0_wdata = 32'h0000_FF01; cp0_req = 1;
    @(negedge clk);
    chk("mtc0_c0_rf_we", rf_we, 1);
    chk("mtc0_c0_waddr", rf_waddr, 15);
    chk("mtc0_c0_wdata", rf_wdata, 32'h0000_FF01);
    @(negedge clk);
    chk("mtc0_c1_ack", cp0_ack, 1);
    @(posedge clk); #1 cp0_req = 0;
    chk("mtc0_status_val", rf[15], 32'h0000_FF01);

    do_cp0(1, 5'd14, 0, 32'hBFC0_0380, rd_v, lat_a);
    do_cp0(0, 5'd14, 0, 32'h0, rd_v, lat_a);
    chk("mfc0_epc_data", rd_v, 32'hBFC0_0380);
    chk("mfc0_epc_lat", lat_a, 1);

    // exception from EXL=0
    do_cp0(1, 5'd12, 0, 32'h0, rd_v, lat_a);
    do_cp0(1, 5'd13, 0, 32'h0, rd_v, lat_a);
    do_exc(5'd4, 32'h8000_1004, 1'b1, 32'hDEAD_0008, 1'b1, lat_a);
    chk("exc0_lat", lat_a, 7);
    chk("exc0_epc", rf[17], 32'h8000_1004);
    chk("exc0_cause", rf[16], 32'h8000_0010);
    chk("exc0_status", rf[15], 32'h0000_0002);
    chk("exc0_badv", rf[8], 32'hDEAD_0008);

    // nested exception (EXL=1): EPC and BD hold, ExcCode moves, BadVAddr skipped
    do_cp0(1, 5'd13, 0, 32'h0, rd_v, lat_a);
    do_exc(5'd7, 32'h8000_2000, 1'b1, 32'h1111_1111, 1'b0, lat_a);
    chk("exc1_lat", lat_a, 7);
    chk("exc1_epc", rf[17], 32'h8000_1004);
    chk("exc1_cause", rf[16], 32'h0000_001C);
    chk("exc1_status", rf[15], 32'h0000_0002);
    chk("exc1_badv", rf[8], 32'hDEAD_0008);

    // simultaneous requests: exception, then ERET, then pipeline
    do_cp0(1, 5'd12, 0, 32'h0000_FF00, rd_v, lat_a);
    fork
      do_exc(5'd2, 32'h8000_3000, 1'b0, 32'h0, 1'b0, lat_a);
      do_eret(pc_v, lat_b);
      do_cp0(0, 5'd12, 0, 32'h0, rd_v, lat_c);
    join
    chk("arb_exc_lat", lat_a, 7);
    chk("arb_eret_lat", lat_b, 11);
    chk("arb_cp0_lat", lat_c, 13);
    chk("arb_eret_pc", pc_v, 32'h8000_3000);
    chk("arb_mfc0_status", rd_v, 32'h0000_FF00);

    do_cp0(0, 5'd5, 4'd3, 32'h0, rd_v, lat_a);
    chk("unmapped_rdata", rd_v, 0);
    chk("unmapped_lat", lat_a, 1);

    // reset while in EXC_WC
    exc_code = 5'd9; exc_epc = 32'h8000_4000; exc_bd = 1; exc_badv = 32'h2222_2222;
    exc_badv_vld = 1; exc_req = 1;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0; exc_req = 0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_exc_ack", exc_ack, 0);
    chk("abort_rf_we", rf_we, 0);
    chk("abort_rf_addrs", {20'd0, rf_raddr, rf_waddr}, 0);
    chk("abort_rdata", cp0_rdata, 0);
    chk("abort_epc", rf[17], 32'h8000_4000);
    chk("abort_badv", rf[8], 32'h2222_2222);
    chk("abort_cause", rf[16], 32'h0000_0008);
    chk("abort_status", rf[15], 32'h0000_FF00);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // random traffic from three independent requesters
    fork
      begin
        for (int n = 0; n < 80; n++) begin
          idle_rand();
          do_cp0(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                 4'($urandom_range(0, 2)), $urandom, rd_v, lat_a);
        end
      end
      begin
        for (int n = 0; n < 25; n++) begin
          idle_rand();
          do_exc(5'($urandom_range(0, 31)), $urandom, 1'($urandom_range(0, 1)),
                 $urandom, 1'($urandom_range(0, 1)), lat_b);
        end
      end
      begin
        for (int n = 0; n < 25; n++) begin
          idle_rand();
          do_eret(pc_v, lat_c);
        end
      end
    join
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
